// File: rtl/sign_extend_pkg.sv
// Shared types and default widths for the immediate-extension unit.
package sign_extend_pkg;

  typedef enum logic [1:0] {
    EXT_SEXT   = 2'b00,
    EXT_ZEXT   = 2'b01,
    EXT_BRANCH = 2'b10,
    EXT_UPPER  = 2'b11
  } ext_mode_t;

  localparam int unsigned IMM_W = 16;
  localparam int unsigned XLEN  = 64;

endpackage

// File: rtl/sign_extend_core.sv
// Combinational immediate extender: maps (imm, mode) to an OUT_W-bit value.
module sign_extend_core
  import sign_extend_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_W,
  parameter int unsigned OUT_W = XLEN
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] ext
);

  if (OUT_W < IN_W + 16) begin : g_width_check
    $error("sign_extend_core: OUT_W must be >= IN_W+16");
  end

  logic [OUT_W-1:0] sext;

  always_comb begin
    sext = {OUT_W{imm[IN_W-1]}};
    sext[IN_W-1:0] = imm;
  end

  // UPPER: fill with the immediate's MSB, then place {imm, 16'h0} in the low bits.
  always_comb begin
    ext = sext;
    unique case (mode)
      EXT_SEXT:   ext = sext;
      EXT_ZEXT: begin
        ext = '0;
        ext[IN_W-1:0] = imm;
      end
      EXT_BRANCH: ext = sext << 2;
      EXT_UPPER: begin
        ext = {OUT_W{imm[IN_W-1]}};
        ext[IN_W+15:0] = {imm, 16'h0000};
      end
      default:    ext = sext;
    endcase
  end

endmodule

// File: rtl/sign_extend.sv
// Immediate-extension unit: combinational imm64 plus a registered, mode-selectable path.
// Optional saturating negative-capture counter enabled by SIGN_EXTEND_NEGCOUNT_EN.
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_W,
  parameter int unsigned OUT_W = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  imm16,
  output logic [OUT_W-1:0] imm64,
  input  logic             in_valid,
  input  logic [1:0]       ext_mode,
  output logic [OUT_W-1:0] imm_q,
  output logic             out_valid
`ifdef SIGN_EXTEND_NEGCOUNT_EN
  ,
  output logic [15:0]      neg_count
`endif
);

  logic [OUT_W-1:0] sel_ext;
  logic [OUT_W-1:0] imm_reg_d, imm_reg_q;
  logic             vld_d, vld_q;

  sign_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core_comb (
    .imm  (imm16),
    .mode (EXT_SEXT),
    .ext  (imm64)
  );

  sign_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core_reg (
    .imm  (imm16),
    .mode (ext_mode_t'(ext_mode)),
    .ext  (sel_ext)
  );

  always_comb begin
    imm_reg_d = imm_reg_q;
    vld_d     = in_valid;
    if (in_valid) imm_reg_d = sel_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_reg_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      imm_reg_q <= imm_reg_d;
      vld_q     <= vld_d;
    end
  end

  assign imm_q     = imm_reg_q;
  assign out_valid = vld_q;

`ifdef SIGN_EXTEND_NEGCOUNT_EN
  logic [15:0] neg_cnt_d, neg_cnt_q;

  always_comb begin
    neg_cnt_d = neg_cnt_q;
    if (in_valid && imm16[IN_W-1] && (neg_cnt_q != '1)) neg_cnt_d = neg_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg_cnt_q <= '0;
    else        neg_cnt_q <= neg_cnt_d;
  end

  assign neg_count = neg_cnt_q;
`endif

endmodule

// File: tb/tb_sign_extend.sv
// Self-checking bench for sign_extend against an arithmetic reference model.
module tb_sign_extend;

  localparam int IN_W  = 16;
  localparam int OUT_W = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IN_W-1:0]  imm16;
  logic [OUT_W-1:0] imm64;
  logic             in_valid;
  logic [1:0]       ext_mode;
  logic [OUT_W-1:0] imm_q;
  logic             out_valid;
`ifdef SIGN_EXTEND_NEGCOUNT_EN
  logic [15:0]      neg_count;
`endif

  int errors = 0;
  int checks = 0;

  sign_extend #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imm16     (imm16),
    .imm64     (imm64),
    .in_valid  (in_valid),
    .ext_mode  (ext_mode),
    .imm_q     (imm_q),
    .out_valid (out_valid)
`ifdef SIGN_EXTEND_NEGCOUNT_EN
    ,
    .neg_count (neg_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: immediate value as a signed integer, scaled arithmetically per mode.
  function automatic logic [63:0] model(input logic [15:0] imm, input logic [1:0] mode);
    longint s;
    s = longint'($signed(imm));
    case (mode)
      2'd0:    return 64'(s);
      2'd1:    return {48'h0, imm};
      2'd2:    return 64'(s * 4);
      default: return 64'(s * 65536);
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; ext_mode = 2'b00; imm16 = '0;
    #3;
    checks++;
    if (imm_q !== '0) begin errors++; $display("FAIL reset_imm_q got=%h exp=0", imm_q); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_comb();
    logic [15:0] ins [4];
    logic [63:0] exps [4];
    ins[0] = 16'h0001; exps[0] = 64'h0000_0000_0000_0001;
    ins[1] = 16'h7FFF; exps[1] = 64'h0000_0000_0000_7FFF;
    ins[2] = 16'h8000; exps[2] = 64'hFFFF_FFFF_FFFF_8000;
    ins[3] = 16'hFFFF; exps[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin in_valid = 1'bz; ext_mode = 2'bzz; end
      for (int i = 0; i < 4; i++) begin
        imm16 = ins[i];
        #1;
        checks++;
        if (imm64 !== exps[i]) begin
          errors++; $display("FAIL comb_imm64 pass=%0d in=%h got=%h exp=%h", pass, ins[i], imm64, exps[i]);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      imm16 = 16'($urandom);
      #1;
      checks++;
      if (imm64 !== model(imm16, 2'd0)) begin
        errors++; $display("FAIL comb_rand in=%h got=%h exp=%h", imm16, imm64, model(imm16, 2'd0));
      end
    end
    in_valid = 1'b0; ext_mode = 2'b00;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_modes();
    logic [63:0] exps [4];
    exps[0] = 64'hFFFF_FFFF_FFFF_8001;
    exps[1] = 64'h0000_0000_0000_8001;
    exps[2] = 64'hFFFF_FFFF_FFFE_0004;
    exps[3] = 64'hFFFF_FFFF_8001_0000;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      imm16 = 16'h8001; ext_mode = 2'(m); in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (imm_q !== exps[m] || out_valid !== 1'b1) begin
        errors++; $display("FAIL mode%0d imm_q=%h vld=%b exp=%h vld=1", m, imm_q, out_valid, exps[m]);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (imm_q !== exps[m] || out_valid !== 1'b0) begin
        errors++; $display("FAIL mode%0d_hold imm_q=%h vld=%b exp=%h vld=0", m, imm_q, out_valid, exps[m]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      imm16 = 16'(i); ext_mode = 2'b00; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (imm_q !== 64'(i) || out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_%0d imm_q=%h vld=%b exp=%h vld=1", i, imm_q, out_valid, 64'(i));
      end
    end
    @(negedge clk);
    in_valid = 1'b0; imm16 = 16'hABCD;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (imm_q !== 64'h3 || out_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_hold imm_q=%h vld=%b exp=3 vld=0", imm_q, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_q;
    logic        exp_v;
    exp_q = imm_q === 64'h3 ? 64'h3 : 64'hx;
    exp_v = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      imm16 = 16'($urandom); ext_mode = 2'($urandom_range(0, 3)); in_valid = 1'($urandom_range(0, 1));
      if (in_valid) exp_q = model(imm16, ext_mode);
      exp_v = in_valid;
      @(posedge clk); #1;
      checks++;
      if (imm_q !== exp_q || out_valid !== exp_v) begin
        errors++; $display("FAIL random_%0d imm_q=%h vld=%b exp=%h vld=%b", i, imm_q, out_valid, exp_q, exp_v);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    imm16 = 16'h1234; ext_mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imm_q !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset imm_q=%h vld=%b exp=0 vld=0", imm_q, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; imm16 = 16'hC000; ext_mode = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (imm_q !== 64'hFFFF_FFFF_C000_0000 || out_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_capture imm_q=%h vld=%b exp=ffffffffc0000000 vld=1", imm_q, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

`ifdef SIGN_EXTEND_NEGCOUNT_EN
  task automatic test_negcount();
    logic [15:0] seq [3];
    seq[0] = 16'h8000; seq[1] = 16'h7FFF; seq[2] = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (neg_count !== 16'h0) begin errors++; $display("FAIL negcnt_reset got=%h exp=0", neg_count); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imm16 = seq[i]; ext_mode = 2'($urandom_range(0, 3)); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (neg_count !== 16'd2) begin errors++; $display("FAIL negcnt_count got=%h exp=2", neg_count); end
    force dut.neg_cnt_q = 16'hFFFE;
    #1;
    release dut.neg_cnt_q;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imm16 = 16'h8000 | 16'($urandom); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (neg_count !== 16'hFFFF) begin errors++; $display("FAIL negcnt_sat got=%h exp=ffff", neg_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_comb();
    release_reset();
    test_modes();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef SIGN_EXTEND_NEGCOUNT_EN
    test_negcount();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sign_extend.md
Name: sign_extend

Overview:
- Immediate-extension unit for the single-cycle 64-bit datapath, sitting between instruction decode and the ALU B-operand mux.
- Always-valid combinational path imm64: 16-bit immediate sign-extended to 64 bits.
- Registered, mode-selectable path imm_q/out_valid for pipelined or multi-cycle users.

Parameters:
- IN_W, 16, immediate input width.
- OUT_W, 64, output width; required OUT_W >= IN_W+16 (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock; registered path only.
- rst_n  input  1  asynchronous active-low reset.
- imm16  input  IN_W  raw immediate field.
- imm64  output  OUT_W  combinational sign extension of imm16.
- in_valid  input  1  capture request for the registered path.
- ext_mode  input  2  registered-path mode: 00 SEXT, 01 ZEXT, 10 BRANCH, 11 UPPER.
- imm_q  output  OUT_W  registered extended immediate.
- out_valid  output  1  high for one cycle after each accepted in_valid.

Behaviour:
- imm64 = {(OUT_W-IN_W){imm16[IN_W-1]}, imm16}.
  - Pure combinational; zero latency.
  - Independent of clk, rst_n, in_valid and ext_mode, including while in reset and when those inputs are left unconnected (z).
- Registered result is selected by ext_mode:
  - SEXT: same value as imm64.
  - ZEXT: zero-filled upper bits.
  - BRANCH: sign-extended value shifted left 2. Bits shifted past OUT_W-1 are discarded; low 2 bits are 0.
  - UPPER: {imm16, 16'h0000} treated as a 32-bit value, then sign-extended from bit 31 to OUT_W.
- Rising clk with in_valid=1: imm_q <= selected result; out_valid <= 1.
- Rising clk with in_valid=0: imm_q holds; out_valid <= 0.
- Latency: one cycle from accepted in_valid to out_valid/imm_q. Back-to-back in_valid is accepted every cycle; there is no stall or backpressure.
- Reset (rst_n=0, asynchronous, any time):
  - imm_q = 0, out_valid = 0 immediately.
  - A capture in flight is dropped.
  - The first capture is possible on the first rising clk after rst_n deasserts.
- ext_mode or in_valid carrying X/z while in_valid is sampled high: imm_q undefined. The bench must drive both cleanly whenever the registered path is used.

Optional Feature:
- Macro: SIGN_EXTEND_NEGCOUNT_EN.
- When defined:
  - Adds output neg_count, 16 bits.
  - Increments on each accepted capture whose imm16[IN_W-1]=1, regardless of mode.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst_n.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package sign_extend_pkg holds:
  - ext_mode_t enum: EXT_SEXT=2'b00, EXT_ZEXT=2'b01, EXT_BRANCH=2'b10, EXT_UPPER=2'b11.
  - Default width constants IMM_W=16, XLEN=64.
- One natural combinational sub-module, sign_extend_core: maps (imm, mode) to the extended value. Instantiated twice:
  - once with mode tied to EXT_SEXT for imm64;
  - once with ext_mode for the register input.

Test Plan:
- Combinational, no clock: imm16=0001 -> imm64=0000_0000_0000_0001; 7FFF -> 0000_0000_0000_7FFF; 8000 -> FFFF_FFFF_FFFF_8000; FFFF -> FFFF_FFFF_FFFF_FFFF. Repeat with rst_n=0 and with ext_mode/in_valid floating; results unchanged.
- Registered modes with imm16=8001, one capture each -> after one clk:
  - SEXT: FFFF_FFFF_FFFF_8001.
  - ZEXT: 0000_0000_0000_8001.
  - BRANCH: FFFF_FFFF_FFFE_0004.
  - UPPER: FFFF_FFFF_8001_0000.
  - out_valid=1 for exactly one cycle each.
- Back-to-back: in_valid high for 3 cycles with SEXT on 0001, 0002, 0003 -> imm_q follows one cycle later with out_valid high for 3 consecutive cycles; in_valid=0 afterwards -> imm_q holds 0003, out_valid drops.
- Async reset mid-stream: assert rst_n=0 between clock edges right after a capture -> imm_q=0 and out_valid=0 without a clock edge; first capture after release works normally.
- With SIGN_EXTEND_NEGCOUNT_EN: captures of 8000, 7FFF, FFFF -> neg_count=2. Force neg_count to FFFE, then apply three negative captures -> neg_count stays FFFF.
